mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter. It is the responder on the CPU data bus, sitting behind the address decoder's UART window.
- The decoder forwards ren/wen plus the low address bits.
- The block buffers written bytes in a FIFO and serialises them 8N1 on the tx pin.
- It returns status and configuration on reads, which the decoder muxes into the CPU's read data.

---
 rtl/uart_tx_pkg.sv | 38 +++
 rtl/uart_tx_fifo.sv | 68 ++++++
 rtl/mmio_uart_tx.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register map, bit positions and FSM encoding shared by the
// MMIO UART transmitter and its bench-facing documentation.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and CTRL.parity_odd).
package uart_tx_pkg;

    // Byte offsets inside the UART window; addr[1:0] is ignored by the decoder.
    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] DIV_OFS    = 4'h8;
    localparam logic [3:0] CTRL_OFS   = 4'hC;

    // STATUS bit positions.
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;

    // CTRL bit positions.
    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_CLEAR_BIT      = 1;
    localparam int CTRL_PARITY_ODD_BIT = 2;

    // Transmit FSM encoding; ST_PARITY is only reachable in the parity build.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // A programmed divisor of zero behaves like one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with push, pop and a clear that wins over
// both. A push into a full FIFO is accepted only when a pop happens in the
// same cycle. DEPTH must be a power of two (2..256) so the pointers wrap.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; clear discards everything queued.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Storage write; contents are only meaningful below count_q.
    // NOTE: the storage array has no reset on purpose -- empty/count guard every read, and it stays a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter behind the CPU bus
// decoder. DATA writes feed a TX FIFO, the FSM serialises bytes LSB-first
// with a divisor latched per frame, and STATUS/BAUD_DIV/CTRL read back
// through a registered rdata.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, CTRL.parity_odd).
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd234
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic [3:0] reg_ofs;
    logic       rd_sel;
    logic       data_push;
    logic       status_rd;

    assign reg_ofs   = {addr[3:2], 2'b00};
    assign rd_sel    = ren && !wen;
    assign data_push = wen && (reg_ofs == DATA_OFS);
    assign status_rd = rd_sel && (reg_ofs == STATUS_OFS);

    logic unused_bits;
    assign unused_bits = ^{wdata[31:16], addr[1:0]};

    // Configuration / status registers
    logic [15:0] baud_div_q;
    logic        ctrl_enable_q;
    logic        clear_q;
    logic        overflow_q;
    logic [31:0] rdata_q;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd_q;
`endif

    // FIFO interface
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;

    // Transmit FSM state
    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic        tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif
    logic        bit_done;
    logic        start_frame;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (data_push),
        .pop_i   (fifo_pop),
        .clear_i (clear_q),
        .wdata_i (wdata[7:0]),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register writes; clear_fifo is a one-cycle pulse applied on the following edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            baud_div_q    <= DIV_RESET;
            ctrl_enable_q <= 1'b1;
            clear_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_odd_q  <= 1'b0;
`endif
        end else begin
            clear_q <= 1'b0;
            if (wen) begin
                case (reg_ofs)
                    DIV_OFS: baud_div_q <= wdata[15:0];
                    CTRL_OFS: begin
                        ctrl_enable_q <= wdata[CTRL_ENABLE_BIT];
                        clear_q       <= wdata[CTRL_CLEAR_BIT];
`ifdef UART_TX_PARITY_EN
                        parity_odd_q  <= wdata[CTRL_PARITY_ODD_BIT];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sticky overflow: set by a dropped push, cleared by a STATUS read
    // (writes win over reads, so the two never coincide).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (data_push && fifo_full && !fifo_pop && !clear_q) begin
            overflow_q <= 1'b1;
        end else if (status_rd) begin
            overflow_q <= 1'b0;
        end
    end

    // Read mux; fill count is the low 8 bits of the occupancy.
    logic [31:0] rd_word;
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rd_word = '0;
        case (reg_ofs)
            STATUS_OFS: begin
                rd_word[STAT_BUSY_BIT]           = (state_q != ST_IDLE);
                rd_word[STAT_FULL_BIT]           = fifo_full;
                rd_word[STAT_EMPTY_BIT]          = fifo_empty;
                rd_word[STAT_OVF_BIT]            = overflow_q;
                rd_word[STAT_COUNT_LSB +: 8]     = 8'(fifo_count);
            end
            DIV_OFS: rd_word[15:0] = baud_div_q;
            CTRL_OFS: begin
                rd_word[CTRL_ENABLE_BIT] = ctrl_enable_q;
`ifdef UART_TX_PARITY_EN
                rd_word[CTRL_PARITY_ODD_BIT] = parity_odd_q;
`endif
            end
            default: ;
        endcase
    end

    // Registered read data: updates only on a read that is not overridden by a write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (rd_sel) begin
            rdata_q <= rd_word;
        end
    end

    assign rdata = rdata_q;

    // A frame starts from IDLE only when enabled, data is queued and no clear is pending.
    assign start_frame = (state_q == ST_IDLE) && ctrl_enable_q && !fifo_empty && !clear_q;
    assign fifo_pop    = start_frame;
    assign bit_done    = (baud_cnt_q == (div_lat_q - 16'd1));

    // Next-state logic: one bit-time per div_lat_q clocks, tx registered with the state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        div_lat_d  = div_lat_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    state_d    = ST_START;
                    shift_d    = fifo_head;
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = 16'd0;
                    div_lat_d  = eff_div(baud_div_q);
`ifdef UART_TX_PARITY_EN
                    parity_d   = (^fifo_head) ^ parity_odd_q;
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = 16'd0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    baud_cnt_d = 16'd0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    state_d    = ST_IDLE;
                    baud_cnt_d = 16'd0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // FSM registers; reset forces the line idle immediately and abandons any frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            div_lat_q  <= 16'd1;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            div_lat_q  <= div_lat_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx. Stimulus pushes
// expected read data and expected serial frames into queues; a read monitor
// and a serial-line receiver pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS = PAR_EN ? 11 : 10;

    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_DIV    = 4'h8;
    localparam logic [3:0] A_CTRL   = 4'hC;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;

    always #5 clk = ~clk;

    mmio_uart_tx dut (
        .clk    (clk),
        .resetn (resetn),
        .ren    (ren),
        .wen    (wen),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .tx     (tx)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic [31:0] val;
        string       name;
    } rd_t;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         par_odd;
        bit         b2b;
    } frame_t;

    rd_t    rd_exp[$];
    frame_t exp_frames[$];

    function automatic logic frame_bit(input frame_t f, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return f.data[i-1];
        if (PAR_EN && i == 9) return (^f.data) ^ f.par_odd;
        return 1'b1;
    endfunction

    // ---------------- read monitor ----------------
    bit rd_fire = 1'b0;
    always @(posedge clk) rd_fire <= resetn && ren && !wen;

    always @(negedge clk) begin
        if (rd_fire) begin
            if (rd_exp.size() == 0) begin
                fail("unexpected_read_response");
            end else begin
                rd_t e;
                e = rd_exp.pop_front();
                check(e.name, rdata, e.val);
            end
        end
    end

    // ---------------- serial receiver ----------------
    frame_t rx_cur;
    bit     rx_active = 1'b0;
    bit     orphan = 1'b0;
    int     rx_k = 0;
    int     rx_errs = 0;
    int     idle_cnt = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            rx_active = 1'b0;
            orphan    = 1'b0;
            idle_cnt  = 0;
        end else begin
            if (!rx_active) begin
                if (tx === 1'b1) begin
                    idle_cnt++;
                    if (idle_cnt >= 128) orphan = 1'b0;
                end else if (exp_frames.size() == 0) begin
                    if (!orphan) fail("unexpected_frame_start");
                    orphan   = 1'b1;
                    idle_cnt = 0;
                end else begin
                    rx_cur    = exp_frames.pop_front();
                    rx_active = 1'b1;
                    rx_k      = 0;
                    rx_errs   = 0;
                    if (rx_cur.b2b)
                        check($sformatf("idle_gap_before_%02h", rx_cur.data), idle_cnt, 1);
                end
            end
            if (rx_active) begin
                if (tx !== frame_bit(rx_cur, rx_k / rx_cur.div)) rx_errs++;
                rx_k++;
                if (rx_k == NBITS * rx_cur.div) begin
                    check($sformatf("frame_%02h_div%0d_bad_samples", rx_cur.data, rx_cur.div), rx_errs, 0);
                    rx_active = 1'b0;
                    idle_cnt  = 0;
                end
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wen = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        rd_t e;
        e.val = exp;
        e.name = name;
        rd_exp.push_back(e);
        @(posedge clk); #1;
        ren = 1'b1; addr = a;
        @(posedge clk); #1;
        ren = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] d, input int div, input bit odd, input bit b2b);
        frame_t f;
        f.data = d; f.div = div; f.par_odd = odd; f.b2b = b2b;
        exp_frames.push_back(f);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while (i < budget && (exp_frames.size() != 0 || rx_active)) begin
            @(negedge clk);
            i++;
        end
        check(name, {31'b0, (exp_frames.size() != 0 || rx_active)}, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_idle", {31'b0, tx}, 32'h1);
        check("reset_rdata", rdata, 32'h0);
        resetn = 1'b1;
        bus_read(A_STATUS, 32'h0000_0004, "status_after_reset");
        bus_read(A_DIV,    32'd234,       "baud_div_reset");
        bus_read(A_CTRL,   32'h0000_0001, "ctrl_reset");
        bus_read(A_DATA,   32'h0000_0000, "data_reads_zero");

        // Register readback widths
        bus_write(A_DIV, 32'hFFFF_0010);
        bus_read(A_DIV, 32'h0000_0010, "baud_div_upper_zero");
        bus_write(A_CTRL, 32'h0000_0007);
        bus_read(A_CTRL, PAR_EN ? 32'h0000_0005 : 32'h0000_0001, "ctrl_readback");
        bus_write(A_CTRL, 32'h0000_0001);

        // Single frame 0xA5 at div 4, busy during the frame
        bus_write(A_DIV, 32'd4);
        expect_frame(8'hA5, 4, 1'b0, 1'b0);
        bus_write(A_DATA, 32'h0000_00A5);
        bus_read(A_STATUS, 32'h0000_0005, "status_busy_in_frame");
        wait_drain("drain_a5", 200);
        bus_read(A_STATUS, 32'h0000_0004, "status_idle_after_a5");

        // Fill while disabled: 17 pushes -> full, count 16, overflow; then drain 16
        bus_write(A_CTRL, 32'h0000_0000);
        for (int i = 0; i <= 16; i++) bus_write(A_DATA, 32'(i));
        bus_read(A_STATUS, 32'h0000_100A, "status_full_overflow");
        bus_read(A_STATUS, 32'h0000_1002, "status_overflow_cleared");
        for (int i = 0; i < 16; i++) expect_frame(8'(i), 4, 1'b0, i != 0);
        bus_write(A_CTRL, 32'h0000_0001);
        wait_drain("drain_16_frames", 16 * 60 + 100);
        bus_read(A_STATUS, 32'h0000_0004, "status_after_16_frames");

        // Divisor 0 behaves as 1; mid-frame divisor change applies to the next frame
        bus_write(A_DIV, 32'd0);
        expect_frame(8'h3C, 1, 1'b0, 1'b0);
        bus_write(A_DATA, 32'h0000_003C);
        wait_drain("drain_div0", 100);
        expect_frame(8'h96, 1, 1'b0, 1'b0);
        expect_frame(8'h5A, 8, 1'b0, 1'b1);
        bus_write(A_DATA, 32'h0000_0096);
        bus_write(A_DATA, 32'h0000_005A);
        bus_write(A_DIV, 32'd8);
        wait_drain("drain_div_change", 300);
        bus_read(A_DIV, 32'd8, "baud_div_8");

        // clear_fifo mid-frame: in-flight frame completes, queued bytes discarded
        bus_write(A_DIV, 32'd4);
        bus_write(A_CTRL, 32'h0000_0000);
        bus_write(A_DATA, 32'h0000_0011);
        bus_write(A_DATA, 32'h0000_0022);
        bus_write(A_DATA, 32'h0000_0033);
        bus_write(A_DATA, 32'h0000_0044);
        expect_frame(8'h11, 4, 1'b0, 1'b0);
        bus_write(A_CTRL, 32'h0000_0001);
        bus_write(A_CTRL, 32'h0000_0003);
        bus_read(A_STATUS, 32'h0000_0005, "status_after_clear_midframe");
        wait_drain("drain_after_clear", 200);
        repeat (20) @(negedge clk);
        bus_read(A_STATUS, 32'h0000_0004, "status_no_restart_after_clear");

        // Asynchronous reset mid-frame: line returns high without waiting for a clock
        expect_frame(8'h00, 4, 1'b0, 1'b0);
        bus_write(A_DATA, 32'h0000_0000);
        repeat (6) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("tx_high_on_async_reset", {31'b0, tx}, 32'h1);
        check("rdata_zero_on_async_reset", rdata, 32'h0);
        exp_frames.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        bus_read(A_STATUS, 32'h0000_0004, "status_after_midframe_reset");
        bus_read(A_DIV,    32'd234,       "baud_div_after_midframe_reset");

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0
        bus_write(A_DIV, 32'd2);
        expect_frame(8'h07, 2, 1'b0, 1'b0);
        bus_write(A_DATA, 32'h0000_0007);
        bus_write(A_CTRL, 32'h0000_0005);
        expect_frame(8'h07, 2, 1'b1, 1'b1);
        bus_write(A_DATA, 32'h0000_0007);
        wait_drain("drain_parity", 200);
        bus_write(A_CTRL, 32'h0000_0001);
`endif

        repeat (5) @(negedge clk);
        check("read_scoreboard_empty", 32'(rd_exp.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
